// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one byte-wide memory port between the fetch
// requester (4-byte reads) and the data requester (8-byte loads/stores).
// Each granted request is serialized into little-endian byte cycles. Read
// bytes are reassembled into a single response word.
// Build option: define MEM_ARB_RR_EN for round-robin tie breaking. Without
// it, data wins every tie and no last-grant register exists.
module mem_port_arbiter #(
  parameter int MEM_BYTES = 524288,
  parameter int MA_W      = $clog2(MEM_BYTES)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            if_req,
  input  logic [63:0]     if_addr,
  output logic            if_gnt,
  output logic            if_valid,
  output logic [31:0]     if_rdata,
  output logic            if_err,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [63:0]     d_addr,
  input  logic [63:0]     d_wdata,
  output logic            d_gnt,
  output logic            d_valid,
  output logic [63:0]     d_rdata,
  output logic            d_err,
  output logic [MA_W-1:0] mem_addr,
  output logic            mem_we,
  output logic [7:0]      mem_wdata,
  input  logic [7:0]      mem_rdata,
  output logic            busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_XFER  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  // Latched request. Length is implied by the owner (data = 8, fetch = 4).
  typedef struct packed {
    logic            own_d;
    logic            we;
    logic [MA_W-1:0] base;
    logic [63:0]     wdata;
  } req_t;

  logic [1:0]  state;
  req_t        cur;
  req_t        nreq;
  logic [2:0]  k;
  logic [2:0]  k_nxt;
  logic [2:0]  len_m1;
  logic        last_xfer;
  logic [63:0] rbuf;
  logic [63:0] rbuf_nxt;
  logic        cap_en;
  logic [2:0]  cap_idx;
  logic        any_gnt;
  logic        tie_d;
  logic [63:0] req_addr;
  logic [64:0] req_end;
  logic        oor;
  logic        resp_go;
  logic        resp_err;
  logic        resp_own_d;
  logic        resp_ld;

`ifdef MEM_ARB_RR_EN
  logic last_d;

  // A tie goes to whichever requester was not granted last.
  assign tie_d = ~last_d;

  // Track the most recent winner; error grants count too.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       last_d <= 1'b0;
    else if (d_gnt)  last_d <= 1'b1;
    else if (if_gnt) last_d <= 1'b0;
  end
`else
  assign tie_d = 1'b1;
`endif

  // Grant only from IDLE, and never while reset is asserted.
  always_comb begin
    if_gnt = 1'b0;
    d_gnt  = 1'b0;
    if (!reset && state == S_IDLE) begin
      if (d_req && (!if_req || tie_d)) d_gnt  = 1'b1;
      else if (if_req)                 if_gnt = 1'b1;
    end
  end

  assign any_gnt = if_gnt | d_gnt;
  assign busy    = (state != S_IDLE);

  // Build the request to latch and range-check it in 65 bits, so a base
  // near 2^64 cannot wrap around into range.
  always_comb begin
    req_addr   = d_gnt ? d_addr : if_addr;
    nreq.own_d = d_gnt;
    nreq.we    = d_gnt & d_we;
    nreq.base  = req_addr[MA_W-1:0];
    nreq.wdata = d_gnt ? d_wdata : '0;
    req_end    = {1'b0, req_addr} + (d_gnt ? 65'd8 : 65'd4);
    oor        = req_end > 65'(MEM_BYTES);
  end

  assign len_m1    = cur.own_d ? 3'd7 : 3'd3;
  assign last_xfer = (k == len_m1);
  assign k_nxt     = k + 3'd1;

  // Synchronous read: the byte addressed in XFER step k arrives one cycle
  // later, so capture lags the address by one. DRAIN catches the last byte.
  always_comb begin
    cap_en   = 1'b0;
    cap_idx  = 3'd0;
    rbuf_nxt = rbuf;
    if (state == S_XFER && !cur.we && k != 3'd0) begin
      cap_en  = 1'b1;
      cap_idx = k - 3'd1;
    end else if (state == S_DRAIN) begin
      cap_en  = 1'b1;
      cap_idx = len_m1;
    end
    if (cap_en) rbuf_nxt[{cap_idx, 3'b000} +: 8] = mem_rdata;
  end

  // Sequencer and registered memory port. Outside XFER the port idles at 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      cur       <= '0;
      k         <= 3'd0;
      rbuf      <= '0;
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (any_gnt) begin
            cur  <= nreq;
            k    <= 3'd0;
            rbuf <= '0;
            if (oor) begin
              state <= S_RESP;
            end else begin
              state     <= S_XFER;
              mem_addr  <= nreq.base;
              mem_we    <= nreq.we;
              mem_wdata <= nreq.wdata[7:0];
            end
          end
        end
        S_XFER: begin
          rbuf <= rbuf_nxt;
          if (last_xfer) begin
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
            state     <= cur.we ? S_RESP : S_DRAIN;
          end else begin
            k         <= k_nxt;
            mem_addr  <= cur.base + MA_W'(k_nxt);
            mem_we    <= cur.we;
            mem_wdata <= cur.wdata[{k_nxt, 3'b000} +: 8];
          end
        end
        S_DRAIN: begin
          rbuf  <= rbuf_nxt;
          state <= S_RESP;
        end
        default: begin
          state <= S_IDLE;
          k     <= 3'd0;
        end
      endcase
    end
  end

  // Response is loaded on the edge that enters RESP, so valid is high
  // exactly during RESP.
  always_comb begin
    resp_go    = 1'b0;
    resp_err   = 1'b0;
    resp_own_d = cur.own_d;
    resp_ld    = !cur.we;
    if (state == S_IDLE && any_gnt && oor) begin
      resp_go    = 1'b1;
      resp_err   = 1'b1;
      resp_own_d = d_gnt;
      resp_ld    = 1'b1;
    end else if (state == S_XFER && last_xfer && cur.we) begin
      resp_go = 1'b1;
    end else if (state == S_DRAIN) begin
      resp_go = 1'b1;
    end
  end

  // Response registers: strobes last one cycle, data/err hold until the
  // owner's next response. Stores leave d_rdata untouched.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      if_valid <= 1'b0;
      if_rdata <= '0;
      if_err   <= 1'b0;
      d_valid  <= 1'b0;
      d_rdata  <= '0;
      d_err    <= 1'b0;
    end else begin
      if_valid <= 1'b0;
      d_valid  <= 1'b0;
      if (resp_go) begin
        if (resp_own_d) begin
          d_valid <= 1'b1;
          d_err   <= resp_err;
          if (resp_ld) d_rdata <= resp_err ? 64'h0 : rbuf_nxt;
        end else begin
          if_valid <= 1'b1;
          if_err   <= resp_err;
          if_rdata <= resp_err ? 32'h0 : rbuf_nxt[31:0];
        end
      end
    end
  end

endmodule
